// File: rtl/dsp_sequencer.sv
// dsp_sequencer: streams the per-frame microprogram into the DSP core on each accepted
// sample tick, waits for the core pipeline to drain, then pulses frame_done.
module dsp_sequencer #(
    parameter int OPCODE_WIDTH      = 6,
    parameter int SAMPLE_ADDR_WIDTH = 10,
    parameter int PARAM_ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH,
    parameter int PROG_ADDR_WIDTH   = 10,
    parameter int PIPE_DEPTH        = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_tick,
    input  logic [PROG_ADDR_WIDTH:0]   prog_length,
    output logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr,
    output logic                       prog_rd_en,
    input  logic [INSTR_WIDTH-1:0]     prog_rd_data,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       overrun_clear
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = PIPE_DEPTH > 1 ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PIPE_DEPTH - 1);
    localparam logic [PROG_ADDR_WIDTH:0] MAX_LEN = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
    localparam logic [PROG_ADDR_WIDTH:0] ONE = 1;

    logic [1:0]               state_q, state_d;
    logic [PROG_ADDR_WIDTH:0] addr_q, addr_d, len_q, len_d, len_c;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     en_q, en_d, valid_q, overrun_q, overrun_d;
    logic                     accept, tick_busy;
    logic [INSTR_WIDTH-1:0]   instr_q;

    assign prog_rd_addr = addr_q[PROG_ADDR_WIDTH-1:0];
    assign prog_rd_en   = en_q;
    assign instruction  = instr_q;
    assign busy         = state_q != IDLE;
    assign frame_done   = state_q == DONE;
    assign overrun      = overrun_q;

    always_comb begin
        accept    = sample_tick & enable & (state_q == IDLE | state_q == DONE);
        tick_busy = sample_tick & enable & (state_q == RUN | state_q == DRAIN);
        len_c     = prog_length > MAX_LEN ? MAX_LEN : prog_length;
        state_d   = state_q;
        addr_d    = addr_q;
        en_d      = en_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        if (accept) begin
            len_d   = len_c;
            addr_d  = '0;
            cnt_d   = '0;
            en_d    = len_c != '0;
            state_d = len_c != '0 ? RUN : DRAIN;
        end else if (state_q == RUN) begin
            // Counter is one bit wider than the address so a full-size program ends without wrapping.
            if (addr_q + ONE == len_q) begin
                state_d = DRAIN;
                en_d    = 1'b0;
                cnt_d   = '0;
            end else begin
                addr_d = addr_q + ONE;
            end
        end else if (state_q == DRAIN) begin
            state_d = cnt_q == CNT_LAST ? DONE : DRAIN;
            cnt_d   = cnt_q + CW'(1);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        overrun_d = tick_busy | (overrun_q & ~overrun_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            valid_q   <= en_q;
            instr_q   <= valid_q ? prog_rd_data : '0;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: directed frame scenarios against a one-cycle-latency program memory model.
module tb_dsp_sequencer;
    localparam int IW = 26;

    logic          clk = 1'b0;
    logic          reset, enable, sample_tick, overrun_clear;
    logic [10:0]   prog_length;
    logic [9:0]    prog_rd_addr;
    logic          prog_rd_en;
    logic [IW-1:0] prog_rd_data = '0;
    logic [IW-1:0] instruction;
    logic          busy, frame_done, overrun;
    logic [IW-1:0] mem [1024];
    logic [39:0]   exp_v;
    int            checks = 0, failures = 0;

    dsp_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .prog_length(prog_length), .prog_rd_addr(prog_rd_addr), .prog_rd_en(prog_rd_en),
        .prog_rd_data(prog_rd_data), .instruction(instruction), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .overrun_clear(overrun_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (prog_rd_en) prog_rd_data <= mem[prog_rd_addr];

    // Observed bundle: {rd_en, rd_addr (masked when idle), instruction, busy, frame_done, overrun}
    wire [39:0] obs = {prog_rd_en, prog_rd_en ? prog_rd_addr : 10'd0, instruction, busy, frame_done, overrun};

    function automatic logic [IW-1:0] word(input int i);
        return {6'((i % 63) + 1), 10'(i), 10'(i * 7 + 3)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; sample_tick = 1'b0; overrun_clear = 1'b0; prog_length = 11'd3;
        step; step;
        reset = 1'b0;
        checks++;
        if (obs !== 40'd0) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, 40'd0); end
        sample_tick = 1'b1;
        step; sample_tick = 1'b0;
        step; sample_tick = 1'b1;
        step; sample_tick = 1'b0;
        exp_v = {1'b1, 10'd2, word(0), 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_prerun got=%h exp=%h", obs, exp_v); end
        reset = 1'b1;
        step;
        checks++;
        if (obs !== 40'd0) begin failures++; $display("FAIL reset_midrun got=%h exp=%h", obs, 40'd0); end
        step; reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step;
            checks++;
            if (obs !== 40'd0) begin failures++; $display("FAIL reset_after k=%0d got=%h exp=%h", k, obs, 40'd0); end
        end
    endtask

    task automatic test_basic;
        prog_length = 11'd3; sample_tick = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step; sample_tick = 1'b0; prog_length = 11'd7;
            exp_v = {k <= 3, k <= 3 ? 10'(k - 1) : 10'd0, (k >= 3 && k <= 5) ? word(k - 3) : 26'd0,
                     k <= 10, k == 10, 1'b0};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
    endtask

    task automatic test_zero_length;
        prog_length = 11'd0; sample_tick = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step; sample_tick = 1'b0;
            exp_v = {1'b0, 10'd0, 26'd0, k <= 7, k == 7, 1'b0};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL zero_len k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
    endtask

    task automatic test_overrun;
        prog_length = 11'd3; sample_tick = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step;
            sample_tick   = k == 5 || k == 8;
            overrun_clear = k == 8 || k == 15;
            exp_v = {k <= 3, k <= 3 ? 10'(k - 1) : 10'd0, (k >= 3 && k <= 5) ? word(k - 3) : 26'd0,
                     k <= 10, k == 10, k >= 6 && k <= 15};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL overrun k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
        overrun_clear = 1'b0;
    endtask

    task automatic test_back_to_back;
        int kk;
        prog_length = 11'd3; sample_tick = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step;
            sample_tick = k == 10;
            kk = k > 10 ? k - 10 : k;
            exp_v = {kk <= 3, kk <= 3 ? 10'(kk - 1) : 10'd0, (kk >= 3 && kk <= 5) ? word(kk - 3) : 26'd0,
                     k <= 20, k == 10 || k == 20, 1'b0};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, obs, exp_v); end
        end
    endtask

    task automatic test_enable;
        enable = 1'b0; prog_length = 11'd3; sample_tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step;
            sample_tick = k == 4;
            checks++;
            if (obs !== 40'd0) begin failures++; $display("FAIL enable_low k=%0d got=%h exp=%h", k, obs, 40'd0); end
        end
        enable = 1'b1;
    endtask

    task automatic test_full_length(input logic [10:0] len);
        prog_length = len; sample_tick = 1'b1;
        for (int k = 1; k <= 1033; k++) begin
            step; sample_tick = 1'b0; prog_length = 11'd5;
            exp_v = {k <= 1024, k <= 1024 ? 10'(k - 1) : 10'd0,
                     (k >= 3 && k <= 1026) ? word(k - 3) : 26'd0, k <= 1031, k == 1031, 1'b0};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL full_len len=%0d k=%0d got=%h exp=%h", len, k, obs, exp_v); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word(i);
        test_reset;
        test_basic;
        test_zero_length;
        test_overrun;
        test_back_to_back;
        test_enable;
        test_full_length(11'd1024);
        test_full_length(11'd2047);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
